// File: rtl/conv_pkg.sv
// Shared constants and arithmetic helpers for the convolution layer datapath.
// Saturation mode of requantize() is selected by CONV_OUTQ_RELU_EN.
package conv_pkg;

  localparam int unsigned CONV_ACC_W = 32;
  localparam int unsigned CONV_PIX_W = 8;

  function automatic int unsigned window_count(input int unsigned img_w,
                                               input int unsigned img_h,
                                               input int unsigned k_w,
                                               input int unsigned k_h);
    return (img_w - k_w + 1) * (img_h - k_h + 1);
  endfunction

  function automatic logic [CONV_PIX_W-1:0] requantize(input logic signed [CONV_ACC_W-1:0] acc,
                                                       input int unsigned shift);
    logic signed [CONV_ACC_W-1:0] s;
    s = acc >>> shift;
`ifdef CONV_OUTQ_RELU_EN
    if (s < 0)
      return '0;
    else if (s > 255)
      return '1;
    else
      return s[CONV_PIX_W-1:0];
`else
    if (s < -128)
      return 8'h80;
    else if (s > 127)
      return 8'h7F;
    else
      return s[CONV_PIX_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; push while full succeeds if a pop frees the slot.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (!do_push && do_pop)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/conv_output_sequencer.sv
// Tracks valid convolution windows, requantizes each lane and streams bytes channel by channel.
// Build option CONV_OUTQ_RELU_EN switches requantization to ReLU + unsigned saturation.
module conv_output_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned NUM_TREES    = 4,
  parameter int unsigned IMG_W        = 28,
  parameter int unsigned IMG_H        = 28,
  parameter int unsigned KERNEL_W     = 3,
  parameter int unsigned KERNEL_H     = 3,
  parameter int unsigned PIPE_LATENCY = 4,
  parameter int unsigned SHIFT        = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  localparam int unsigned CH_W        = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              pixel_in_valid,
  input  logic [CONV_ACC_W*NUM_TREES-1:0]   conv_in,
  output logic [CONV_PIX_W-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CH_W-1:0]                   out_channel,
  output logic                              out_last,
  output logic                              overflow
);

  localparam int unsigned COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned ENTRY_W = NUM_TREES * CONV_PIX_W + 1;

  logic [PIPE_LATENCY-1:0] v_pipe;
  logic [PIPE_LATENCY:0]   v_chain;
  logic                    v_d;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic                    win_valid;
  logic                    win_last;
  logic [ENTRY_W-1:0]      push_data;
  logic [ENTRY_W-1:0]      head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    xfer;
  logic                    pop;
  logic [CH_W-1:0]         idx;

  // Chain includes the live input so a latency of 1 needs no special case.
  assign v_chain = {v_pipe, pixel_in_valid};
  assign v_d     = v_pipe[PIPE_LATENCY-1];

  always_ff @(posedge clock) begin
    if (reset)
      v_pipe <= '0;
    else
      v_pipe <= v_chain[PIPE_LATENCY-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (v_d) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign win_valid = v_d && (col >= COL_W'(KERNEL_W - 1)) && (row >= ROW_W'(KERNEL_H - 1));
  assign win_last  = win_valid && (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(IMG_H - 1));

  for (genvar g = 0; g < NUM_TREES; g++) begin : g_lane
    assign push_data[g*CONV_PIX_W +: CONV_PIX_W] =
      requantize(conv_in[g*CONV_ACC_W +: CONV_ACC_W], SHIFT);
  end
  assign push_data[ENTRY_W-1] = win_last;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (win_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset)
      overflow <= 1'b0;
    else if (win_valid && fifo_full && !pop)
      overflow <= 1'b1;
  end

  assign out_valid   = !fifo_empty;
  assign xfer        = out_valid && out_ready;
  assign pop         = xfer && (idx == CH_W'(NUM_TREES - 1));
  assign out_channel = idx;

  always_ff @(posedge clock) begin
    if (reset)
      idx <= '0;
    else if (xfer)
      idx <= pop ? '0 : idx + CH_W'(1);
  end

  // Head memory is not reset, so payload outputs are gated to read 0 while idle.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = head[idx*CONV_PIX_W +: CONV_PIX_W];
      out_last = head[ENTRY_W-1] && (idx == CH_W'(NUM_TREES - 1));
    end
  end

endmodule

// File: tb/tb_conv_output_sequencer.sv
// Self-checking bench: two sequencers (SHIFT 0 / depth 8 and SHIFT 8 / depth 2) on a 5x5 image,
// compared every cycle against a queue-based window/stream model.
module tb_conv_output_sequencer;

  localparam int unsigned NT     = 2;
  localparam int unsigned IW     = 5;
  localparam int unsigned IH     = 5;
  localparam int unsigned KW     = 3;
  localparam int unsigned KH     = 3;
  localparam int unsigned PL     = 4;
  localparam int unsigned NPIX   = IW * IH;
  localparam int unsigned SHIFT0 = 0;
  localparam int unsigned SHIFT1 = 8;
  localparam int unsigned DEPTH0 = 8;
  localparam int unsigned DEPTH1 = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        pv;
  logic [63:0] conv_in;
  logic        rdy0, rdy1;
  logic [7:0]  o_data  [2];
  logic        o_valid [2];
  logic        o_chan  [2];
  logic        o_last  [2];
  logic        o_ovf   [2];

  always #5 clock = ~clock;

  conv_output_sequencer #(
    .NUM_TREES(NT), .IMG_W(IW), .IMG_H(IH), .KERNEL_W(KW), .KERNEL_H(KH),
    .PIPE_LATENCY(PL), .SHIFT(SHIFT0), .FIFO_DEPTH(DEPTH0)
  ) u_dut0 (
    .clock(clock), .reset(reset), .pixel_in_valid(pv), .conv_in(conv_in),
    .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(rdy0),
    .out_channel(o_chan[0]), .out_last(o_last[0]), .overflow(o_ovf[0])
  );

  conv_output_sequencer #(
    .NUM_TREES(NT), .IMG_W(IW), .IMG_H(IH), .KERNEL_W(KW), .KERNEL_H(KH),
    .PIPE_LATENCY(PL), .SHIFT(SHIFT1), .FIFO_DEPTH(DEPTH1)
  ) u_dut1 (
    .clock(clock), .reset(reset), .pixel_in_valid(pv), .conv_in(conv_in),
    .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(rdy1),
    .out_channel(o_chan[1]), .out_last(o_last[1]), .overflow(o_ovf[1])
  );

  int          checks;
  int          errors;
  logic [16:0] mq [2][$];
  int unsigned m_idx [2];
  bit          m_ovf [2];
  bit          hist [$];
  int unsigned m_pos;
  logic [8:0]  obs [2][$];
  int          conv_mode;
  int          rdy_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] ref_q(input logic [31:0] lane, input int unsigned sh);
    longint v, p, q;
    v = longint'($signed(lane));
    p = longint'(1) << sh;
    q = v / p;
    if ((v % p) != 0 && v < 0) q = q - 1;
`ifdef CONV_OUTQ_RELU_EN
    if (q < 0) q = 0;
    else if (q > 255) q = 255;
`else
    if (q < -128) q = -128;
    else if (q > 127) q = 127;
`endif
    return q[7:0];
  endfunction

  // Called at a falling edge: compare, drive next inputs, advance model, move to next falling edge.
  task automatic step();
    bit          vd, win, wlast, rd;
    int unsigned col, row, dep, sh;
    logic [31:0] l0, l1, pval;
    logic [16:0] head, ent;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_valid", d), 32'(o_valid[d]), 32'(mq[d].size() != 0));
      check($sformatf("d%0d_overflow", d), 32'(o_ovf[d]), 32'(m_ovf[d]));
      check($sformatf("d%0d_channel", d), 32'(o_chan[d]), m_idx[d]);
      if (mq[d].size() != 0) begin
        head = mq[d][0];
        check($sformatf("d%0d_data", d), 32'(o_data[d]), 32'(head[m_idx[d]*8 +: 8]));
        check($sformatf("d%0d_last", d), 32'(o_last[d]), 32'(head[16] && m_idx[d] == NT - 1));
      end
    end
    vd   = hist[PL-1];
    col  = m_pos % IW;
    row  = m_pos / IW;
    pval = row * 16 + col;
    case (conv_mode)
      0:       begin l0 = pval;         l1 = 32'd0 - pval; end
      1:       begin l0 = 32'h7FFF_FFFF; l1 = 32'h8000_0000; end
      2:       begin l0 = 32'h0000_1234; l1 = $urandom; end
      default: begin l0 = $urandom;     l1 = $urandom; end
    endcase
    conv_in = {l1, l0};
    case (rdy_mode)
      0:       begin rdy0 = 1'b1;  rdy1 = 1'b1; end
      1:       begin rdy0 = ~rdy0; rdy1 = 1'($urandom_range(0, 1)); end
      default: begin rdy0 = 1'b1;  rdy1 = 1'b0; end
    endcase
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        mq[d].delete();
        m_idx[d] = 0;
        m_ovf[d] = 1'b0;
      end
      for (int i = 0; i < int'(PL); i++) hist[i] = 1'b0;
      m_pos = 0;
    end else begin
      win   = vd && col >= KW - 1 && row >= KH - 1;
      wlast = win && col == IW - 1 && row == IH - 1;
      for (int d = 0; d < 2; d++) begin
        rd  = (d == 0) ? rdy0 : rdy1;
        dep = (d == 0) ? DEPTH0 : DEPTH1;
        sh  = (d == 0) ? SHIFT0 : SHIFT1;
        if (o_valid[d] && rd) obs[d].push_back({o_last[d], o_data[d]});
        if (mq[d].size() != 0 && rd) begin
          if (m_idx[d] == NT - 1) begin
            m_idx[d] = 0;
            void'(mq[d].pop_front());
          end else begin
            m_idx[d]++;
          end
        end
        if (win) begin
          ent = {wlast, ref_q(l1, sh), ref_q(l0, sh)};
          if (mq[d].size() < dep) mq[d].push_back(ent);
          else m_ovf[d] = 1'b1;
        end
      end
      if (vd) m_pos = (m_pos + 1) % NPIX;
      hist.push_front(pv);
      void'(hist.pop_back());
    end
    @(negedge clock);
  endtask

  task automatic frame();
    for (int i = 0; i < int'(NPIX); i++) begin
      pv = 1'b1;
      step();
    end
    pv = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    pv = 1'b0;
    for (int i = 0; i < int'(PL) + 2; i++) step();
    n = 0;
    while ((o_valid[0] || o_valid[1]) && n < budget) begin
      step();
      n++;
    end
    check("drain_idle", {30'd0, o_valid[1], o_valid[0]}, 32'd0);
  endtask

  task automatic zero_checks(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_data", tag, d), 32'(o_data[d]), 32'd0);
      check($sformatf("%s_d%0d_valid", tag, d), 32'(o_valid[d]), 32'd0);
      check($sformatf("%s_d%0d_chan", tag, d), 32'(o_chan[d]), 32'd0);
      check($sformatf("%s_d%0d_last", tag, d), 32'(o_last[d]), 32'd0);
      check($sformatf("%s_d%0d_ovf", tag, d), 32'(o_ovf[d]), 32'd0);
    end
  endtask

  task automatic clear_obs();
    obs[0].delete();
    obs[1].delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] e;
    int         nlast;
    checks = 0; errors = 0;
    reset = 1'b1; pv = 1'b0; conv_in = '0; rdy0 = 1'b0; rdy1 = 1'b0;
    conv_mode = 0; rdy_mode = 0; m_pos = 0;
    for (int i = 0; i < int'(PL); i++) hist.push_back(1'b0);
    for (int d = 0; d < 2; d++) begin m_idx[d] = 0; m_ovf[d] = 1'b0; end
    @(negedge clock);
    step();
    step();
    reset = 1'b0;
    zero_checks("reset");

    // Ramp lanes: first window at (2,2) gives 0x22 / -0x22.
    clear_obs();
    conv_mode = 0; rdy_mode = 0;
    frame();
    drain(100);
    check("ramp_bytes", obs[0].size(), 32'd18);
    e = obs[0][0];
    check("ramp_first_l0", 32'(e[7:0]), 32'h22);
    e = obs[0][1];
`ifdef CONV_OUTQ_RELU_EN
    check("ramp_first_l1", 32'(e[7:0]), 32'h00);
`else
    check("ramp_first_l1", 32'(e[7:0]), 32'hDE);
`endif
    nlast = 0;
    foreach (obs[0][i]) if (obs[0][i][8]) nlast++;
    check("ramp_last_count", nlast, 32'd1);
    e = obs[0][17];
    check("ramp_last_pos", 32'(e[8]), 32'd1);

    // Saturation extremes.
    clear_obs();
    conv_mode = 1;
    frame();
    drain(100);
    e = obs[0][0];
`ifdef CONV_OUTQ_RELU_EN
    check("sat_hi", 32'(e[7:0]), 32'hFF);
    e = obs[0][1];
    check("sat_lo", 32'(e[7:0]), 32'h00);
`else
    check("sat_hi", 32'(e[7:0]), 32'h7F);
    e = obs[0][1];
    check("sat_lo", 32'(e[7:0]), 32'h80);
`endif

    // SHIFT 8 on the second instance.
    clear_obs();
    conv_mode = 2;
    frame();
    drain(100);
    e = obs[1][0];
    check("shift8", 32'(e[7:0]), 32'h12);

    // Depth-2 instance stalled for a whole frame.
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_obs();
    conv_mode = 3; rdy_mode = 2;
    frame();
    for (int i = 0; i < int'(PL) + 2; i++) step();
    check("stall_overflow", 32'(o_ovf[1]), 32'd1);
    check("stall_no_bytes", obs[1].size(), 32'd0);
    rdy_mode = 0;
    drain(100);
    check("stall_release_bytes", obs[1].size(), 32'd4);

    // Toggling ready and random data over two frames.
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_obs();
    conv_mode = 3; rdy_mode = 1;
    frame();
    for (int i = 0; i < 40 + int'($urandom_range(0, 8)); i++) step();
    frame();
    drain(200);
    check("toggle_bytes", obs[0].size(), 32'd36);

    // Reset in the middle of a frame, then a clean frame.
    rdy_mode = 0; conv_mode = 0;
    for (int i = 0; i < 12; i++) begin
      pv = 1'b1;
      step();
    end
    pv = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    zero_checks("midreset");
    clear_obs();
    frame();
    drain(100);
    check("restart_bytes", obs[0].size(), 32'd18);
    e = obs[0][0];
    check("restart_first", 32'(e[7:0]), 32'h22);
    e = obs[0][17];
    check("restart_last", 32'(e[8]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_output_sequencer.md
Name: conv_output_sequencer

Overview:
- Sits downstream of a convolution layer, which shifts in one 8-bit pixel per clock and presents NUM_TREES parallel 32-bit window sums.
- Tracks which cycles carry fully populated windows, skipping shift-register warm-up and row-wrap windows.
- Requantizes each 32-bit sum to 8 bits, buffers valid windows, and serializes them channel by channel onto an 8-bit valid/ready stream for the next layer.

Parameters:
- NUM_TREES, 4, number of parallel output channels (32-bit lanes of conv_in).
- IMG_W, 28, input image width in pixels.
- IMG_H, 28, input image height in pixels.
- KERNEL_W, 3, window width (equals the layer's parallel shift-register depth).
- KERNEL_H, 3, window height (equals the layer's number of shift-register rows).
- PIPE_LATENCY, 4, cycles from a pixel entering the layer to the sum containing it appearing on conv_in; minimum 1.
- SHIFT, 8, arithmetic right shift applied before saturation; range 0..31.
- FIFO_DEPTH, 8, number of window entries (NUM_TREES bytes each) buffered; power of two.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pixel_in_valid  in  1  high on each cycle a frame pixel is shifted into the layer; a frame is IMG_W*IMG_H consecutive high cycles.
- conv_in  in  32*NUM_TREES  layer sums; lane i is at [32*i+31:32*i], signed two's complement.
- out_data  out  8  requantized channel byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_channel  out  clog2(NUM_TREES) (min 1)  lane index of out_data.
- out_last  out  1  high with the final byte of the final valid window of a frame.
- overflow  out  1  sticky; set when a valid window arrives with the FIFO full.

Behaviour:
- Reset: all outputs 0; counters, FIFO pointers, delay line and serializer index cleared. Reset mid-frame abandons the frame; the next pixel_in_valid begins a new frame at (row 0, col 0).
- Delay line: pixel_in_valid is delayed PIPE_LATENCY cycles to give v_d.
- Position counters:
  - col and row advance only on v_d.
  - col wraps IMG_W-1 to 0 and then increments row.
  - row wraps IMG_H-1 to 0, which ends the frame.
- Window valid: v_d and col >= KERNEL_W-1 and row >= KERNEL_H-1. This yields (IMG_W-KERNEL_W+1)*(IMG_H-KERNEL_H+1) windows per frame.
- Final window: the valid window at col=IMG_W-1, row=IMG_H-1. Its FIFO entry carries a last tag.
- Requantize, per lane, same cycle as capture:
  - Shift: s = conv_in_lane >>> SHIFT (arithmetic).
  - Saturation depends on the optional feature below.
- FIFO push: a valid window pushes the NUM_TREES bytes plus the last tag in the same cycle.
  - If the FIFO is full, the window is dropped, overflow sets, and the counters still advance.
  - Push and pop in the same cycle while full is allowed: the pop frees the slot and the push succeeds.
- Serializer:
  - out_valid = FIFO not empty. out_data and out_channel select lane idx of the head entry.
  - Transfer occurs when out_valid && out_ready; idx increments on transfer.
  - After idx=NUM_TREES-1 transfers, idx returns to 0 and the head entry pops.
  - out_last = head last tag && idx==NUM_TREES-1.
  - out_data, out_channel and out_last hold stable while out_valid && !out_ready.
- Latency: a valid window's lane 0 byte appears on out_data 1 cycle after capture, if the FIFO was empty.
- Throughput: sustained input needs NUM_TREES output cycles per valid window. The FIFO absorbs the border gaps; overflow reports loss.

Optional Feature:
- Macro: CONV_OUTQ_RELU_EN.
- Defined: ReLU then unsigned saturate. s<0 gives 0, s>255 gives 255, otherwise s[7:0].
- Undefined: signed saturate to -128..127, output two's complement.

Decomposition:
- Shared package (conv_pkg):
  - Function computing the valid-window count.
  - Requantize/saturate function.
  - Constant CONV_ACC_W=32.
  - Pixel width constant 8.
- One sub-module: sync_fifo (parameterized width/depth, full/empty, synchronous active-high reset), reusable by other layers.

Test Plan:
- IMG 5x5, KERNEL 3x3, NUM_TREES 2, PIPE_LATENCY 4, SHIFT 0, out_ready=1, conv_in lanes = {row*16+col, -(row*16+col)} -> exactly 9 windows, 18 bytes, first pair (0x22, 0xDE) signed; out_last only on the 18th byte.
- Same config, lane 0 = 0x7FFFFFFF, lane 1 = 0x80000000 -> outputs 127 and -128; with CONV_OUTQ_RELU_EN, outputs 255 and 0.
- SHIFT 8, lane 0 = 0x00001234 -> out_data 0x12.
- FIFO_DEPTH 2, out_ready=0 for the whole frame -> 2 entries retained, overflow=1; release out_ready -> exactly 4 bytes out, then out_valid=0.
- out_ready toggling 1010… -> every byte delivered once, in order, with data held during stalls.
- Reset asserted at pixel 12 of frame, then a new full frame -> outputs 0 in the cycle after reset; the new frame yields the full 9 windows from position (0,0).
